// File: rtl/s38584_slot_scheduler.sv
// s38584_slot_scheduler
// Round-robin scheduler for the 8-slot select/compare datapath. Owns the slot index that
// steers the slot mux and the one-hot slot enables. A grant is held until the slot signals
// done, withdraws its request, or runs for TIMEOUT cycles. Arbitration happens only while
// the two phase words agree, which is the same gating the datapath applies.
//
// Ports:
//   CK         in   clock, rising edge
//   RSTN       in   synchronous active-low reset
//   req        in   per-slot request (level)
//   done       in   per-slot completion (only the granted slot is looked at)
//   phase_a    in   phase word A
//   phase_b    in   phase word B (arbitrate only when equal to phase_a)
//   grant_vld  out  grant active (registered)
//   grant_idx  out  granted slot index (registered, holds last value after release)
//   grant_oh   out  one-hot of grant_idx when grant_vld, else 0
//   timeout    out  one-cycle pulse when a grant is forced off by the hold limit
//   busy       out  scheduler not idle
module s38584_slot_scheduler #(
  parameter int unsigned N_CH    = 8,
  parameter int unsigned IDX_W   = 3,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TO_W    = 5
) (
  input  logic             CK,
  input  logic             RSTN,
  input  logic [N_CH-1:0]  req,
  input  logic [N_CH-1:0]  done,
  input  logic [1:0]       phase_a,
  input  logic [1:0]       phase_b,
  output logic             grant_vld,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N_CH-1:0]  grant_oh,
  output logic             timeout,
  output logic             busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] HOLD    = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             to_q, to_d;

  logic             match;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] ptr_inc;
  logic [IDX_W:0]   idx_plus1;

  assign match = (phase_a == phase_b);

  // Scan ptr, ptr+1, ... with wrap; first requester found wins.
  always_comb begin
    int unsigned cand;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= N_CH) cand = cand - N_CH;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  // Next search starts just past the slot that was last served.
  assign idx_plus1 = {1'b0, idx_q} + 1'b1;
  assign ptr_inc   = (idx_plus1 == (IDX_W+1)'(N_CH)) ? '0 : idx_plus1[IDX_W-1:0];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    idx_d   = idx_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (match && win_found) begin
          state_d = HOLD;
          vld_d   = 1'b1;
          idx_d   = win_idx;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        // Phase mismatch is deliberately ignored here: an issued grant is never revoked.
        cnt_d = cnt_q + 1'b1;
        if (done[idx_q] || !req[idx_q] || (cnt_q == CNT_LAST)) begin
          state_d = RELEASE;
          vld_d   = 1'b0;
          ptr_d   = ptr_inc;
          // done and withdrawal take priority over the hold limit.
          to_d    = !done[idx_q] && req[idx_q];
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CK) begin
    if (!RSTN) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      idx_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      idx_q   <= idx_d;
      to_q    <= to_d;
    end
  end

  assign grant_vld = vld_q;
  assign grant_idx = idx_q;
  assign timeout   = to_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    grant_oh = '0;
    if (vld_q) grant_oh[idx_q] = 1'b1;
  end

endmodule

// File: tb/tb_s38584_slot_scheduler.sv
// Bench for s38584_slot_scheduler: directed scenarios plus a randomized run checked
// cycle by cycle against a transaction-style reference model.
module tb_s38584_slot_scheduler;

  localparam int N       = 8;
  localparam int TIMEOUT = 16;

  logic       CK = 1'b0;
  logic       RSTN;
  logic [7:0] req;
  logic [7:0] done;
  logic [1:0] phase_a;
  logic [1:0] phase_b;
  logic       grant_vld;
  logic [2:0] grant_idx;
  logic [7:0] grant_oh;
  logic       timeout;
  logic       busy;

  int checks = 0;
  int passes = 0;

  s38584_slot_scheduler #(
    .N_CH   (8),
    .IDX_W  (3),
    .TIMEOUT(16),
    .TO_W   (5)
  ) dut (
    .CK       (CK),
    .RSTN     (RSTN),
    .req      (req),
    .done     (done),
    .phase_a  (phase_a),
    .phase_b  (phase_b),
    .grant_vld(grant_vld),
    .grant_idx(grant_idx),
    .grant_oh (grant_oh),
    .timeout  (timeout),
    .busy     (busy)
  );

  always #5 CK = ~CK;

  // Reference model: mode 0 = no grant pending, 1 = slot owned, 2 = one-cycle cooldown.
  // m_held counts cycles the current owner has had the grant.
  int         m_mode = 0;
  int         m_ptr  = 0;
  int         m_idx  = 0;
  int         m_held = 0;
  logic       e_vld  = 1'b0;
  logic [2:0] e_idx  = 3'd0;
  logic [7:0] e_oh   = 8'd0;
  logic       e_to   = 1'b0;
  logic       e_busy = 1'b0;

  always @(posedge CK) begin
    e_to = 1'b0;
    if (RSTN !== 1'b1) begin
      m_mode = 0; m_ptr = 0; m_idx = 0; m_held = 0; e_vld = 1'b0;
    end else if (m_mode == 0) begin
      if (phase_a == phase_b && req != 8'd0) begin
        for (int k = 0; k < N; k++) begin
          if (req[(m_ptr + k) % N]) begin
            m_idx = (m_ptr + k) % N;
            break;
          end
        end
        e_vld = 1'b1; m_held = 1; m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (done[m_idx] || !req[m_idx] || m_held == TIMEOUT) begin
        e_to   = req[m_idx] && !done[m_idx];
        e_vld  = 1'b0;
        m_ptr  = (m_idx + 1) % N;
        m_mode = 2;
      end else begin
        m_held++;
      end
    end else begin
      m_mode = 0;
    end
    e_idx  = m_idx[2:0];
    e_oh   = e_vld ? 8'(1 << m_idx) : 8'd0;
    e_busy = (m_mode != 0);
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    tick();
    RSTN = 1'b1;
  endtask

  task automatic test_reset();
    RSTN = 1'b0; req = 8'hFF; done = 8'h00; phase_a = 2'b00; phase_b = 2'b00;
    repeat (2) tick();
    checks++;
    if ({grant_vld, grant_idx, grant_oh, timeout, busy} !== 14'd0)
      $display("FAIL reset_outputs: got vld=%b idx=%0d oh=%h to=%b busy=%b, want all 0",
               grant_vld, grant_idx, grant_oh, timeout, busy);
    else passes++;
  endtask

  task automatic test_rr_wrap();
    logic [2:0] want [4] = '{3'd0, 3'd7, 3'd0, 3'd7};
    logic [2:0] got  [4];
    logic [7:0] oh_got [4];
    int ng  = 0;
    int age = 0;
    RSTN = 1'b1; req = 8'h81; done = 8'h00; phase_a = 2'b10; phase_b = 2'b10;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      tick();
      if (grant_vld) begin
        age++;
        if (age == 1) begin got[ng] = grant_idx; oh_got[ng] = grant_oh; ng++; end
      end else begin
        age = 0;
      end
      done = (age == 2) ? 8'h81 : 8'h00;
    end
    done = 8'h00;
    checks++;
    if (ng != 4) $display("FAIL rr_grant_count: got %0d grants, want 4", ng);
    else passes++;
    for (int i = 0; i < ng; i++) begin
      checks++;
      if (got[i] !== want[i] || oh_got[i] !== (8'h01 << want[i]))
        $display("FAIL rr_grant%0d: got idx=%0d oh=%h, want idx=%0d oh=%h",
                 i, got[i], oh_got[i], want[i], 8'h01 << want[i]);
      else passes++;
    end
    req = 8'h00;
    repeat (4) tick();
  endtask

  task automatic test_phase_gate();
    do_reset();
    req = 8'h04; phase_a = 2'b01; phase_b = 2'b10;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (grant_vld !== 1'b0 || busy !== 1'b0)
        $display("FAIL phase_gate_block: cycle %0d got vld=%b busy=%b, want 0 0",
                 c, grant_vld, busy);
      else passes++;
    end
    phase_b = 2'b01;
    tick();
    checks++;
    if (grant_vld !== 1'b1 || grant_idx !== 3'd2 || grant_oh !== 8'h04)
      $display("FAIL phase_gate_open: got vld=%b idx=%0d oh=%h, want 1 2 04",
               grant_vld, grant_idx, grant_oh);
    else passes++;
    req = 8'h00;
    repeat (3) tick();
  endtask

  task automatic test_timeout();
    int stage = 0;
    int len = 0;
    int pulses = 0;
    logic [2:0] next_idx = 3'd0;
    do_reset();
    req = 8'h08; phase_a = 2'b11; phase_b = 2'b11;
    for (int c = 0; c < 60 && stage < 3; c++) begin
      tick();
      if (timeout) pulses++;
      case (stage)
        0: if (grant_vld) begin stage = 1; len = 1; req = 8'h28; end
        1: if (grant_vld) len++; else stage = 2;
        2: if (grant_vld) begin stage = 3; next_idx = grant_idx; end
        default: ;
      endcase
    end
    checks++;
    if (len != TIMEOUT) $display("FAIL timeout_len: got %0d cycles, want %0d", len, TIMEOUT);
    else passes++;
    checks++;
    if (pulses != 1) $display("FAIL timeout_pulse: got %0d pulses, want 1", pulses);
    else passes++;
    checks++;
    if (stage != 3 || next_idx !== 3'd5)
      $display("FAIL timeout_next_search: got stage=%0d idx=%0d, want idx=5", stage, next_idx);
    else passes++;
    req = 8'h00;
    repeat (4) tick();
  endtask

  task automatic test_done_at_timeout();
    int len = 0;
    int pulses = 0;
    logic rel_seen = 1'b0;
    do_reset();
    req = 8'h08; phase_a = 2'b00; phase_b = 2'b00;
    for (int c = 0; c < 60 && !rel_seen; c++) begin
      tick();
      if (timeout) pulses++;
      if (grant_vld) len++;
      else if (len > 0) rel_seen = 1'b1;
      done = (len == TIMEOUT) ? 8'h08 : 8'h00;
    end
    done = 8'h00;
    tick();
    if (timeout) pulses++;
    checks++;
    if (!rel_seen || len != TIMEOUT)
      $display("FAIL done_timeout_len: got %0d cycles (released=%b), want %0d", len,
               rel_seen, TIMEOUT);
    else passes++;
    checks++;
    if (pulses != 0) $display("FAIL done_timeout_pulse: got %0d pulses, want 0", pulses);
    else passes++;
    req = 8'h00;
    repeat (3) tick();
  endtask

  task automatic test_withdraw_and_reset();
    do_reset();
    req = 8'h20; phase_a = 2'b01; phase_b = 2'b01;
    for (int c = 0; c < 10 && !grant_vld; c++) tick();
    checks++;
    if (grant_vld !== 1'b1 || grant_idx !== 3'd5)
      $display("FAIL withdraw_grant: got vld=%b idx=%0d, want 1 5", grant_vld, grant_idx);
    else passes++;
    repeat (3) tick();
    req = 8'h00;
    tick();
    checks++;
    if (grant_vld !== 1'b0 || timeout !== 1'b0 || grant_oh !== 8'h00)
      $display("FAIL withdraw_release: got vld=%b to=%b oh=%h, want 0 0 00",
               grant_vld, timeout, grant_oh);
    else passes++;
    repeat (2) tick();
    // Regrant slot 5 (search now starts at 6), then reset in the middle of the hold.
    req = 8'h20;
    for (int c = 0; c < 10 && !grant_vld; c++) tick();
    repeat (2) tick();
    RSTN = 1'b0;
    tick();
    checks++;
    if (grant_vld !== 1'b0 || timeout !== 1'b0 || busy !== 1'b0)
      $display("FAIL midhold_reset: got vld=%b to=%b busy=%b, want 0 0 0",
               grant_vld, timeout, busy);
    else passes++;
    RSTN = 1'b1;
    req = 8'h60;
    for (int c = 0; c < 10 && !grant_vld; c++) tick();
    checks++;
    if (grant_vld !== 1'b1 || grant_idx !== 3'd5)
      $display("FAIL reset_ptr_restart: got vld=%b idx=%0d, want 1 5", grant_vld, grant_idx);
    else passes++;
    req = 8'h00;
    repeat (3) tick();
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset();
    req = 8'h00; done = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      tick();
      checks++;
      if ({grant_vld, grant_idx, grant_oh, timeout, busy} !==
          {e_vld, e_idx, e_oh, e_to, e_busy} || !$onehot0(grant_oh)) begin
        if (errs < 10)
          $display("FAIL random_cycle%0d: got vld=%b idx=%0d oh=%h to=%b busy=%b, want %b %0d %h %b %b",
                   c, grant_vld, grant_idx, grant_oh, timeout, busy,
                   e_vld, e_idx, e_oh, e_to, e_busy);
        errs++;
      end else passes++;
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 11) == 0) req[b] = ~req[b];
      done    = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00;
      phase_a = 2'($urandom);
      phase_b = ($urandom_range(0, 4) != 0) ? phase_a : 2'($urandom);
      RSTN    = ($urandom_range(0, 399) != 0);
    end
    RSTN = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rr_wrap();
    test_phase_gate();
    test_timeout();
    test_done_at_timeout();
    test_withdraw_and_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", passes, checks);
    $fatal(1);
  end

endmodule
